// File: rtl/fetch_skid_buffer.sv
// Two-entry elastic buffer between fetch and decode; ready_o comes from registered state only.
// Optional decode-stall counter on stall_cnt_o when SKID_STALL_CNT_EN is defined.
//
// state | meaning
// EMPTY | main and skid invalid
// BUSY  | main valid, skid invalid
// FULL  | main and skid valid, fetch back-pressured
module fetch_skid_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            ready_i
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] main_instr_q, main_instr_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic accept;
    logic consume;
    logic load_main;
    logic load_skid;
    logic shift_skid;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) state_d = BUSY;
                end
                BUSY: begin
                    if (accept && !consume)      state_d = FULL;
                    else if (!accept && consume) state_d = EMPTY;
                end
                FULL: begin
                    if (consume) state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    // accept already excludes flush, so a flushed input never reaches storage.
    always_comb begin
        ready_o    = (state_q != FULL);
        valid_o    = (state_q == BUSY) || (state_q == FULL);
        accept     = valid_i && ready_o && !flush_i;
        consume    = valid_o && ready_i;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state_q)
            EMPTY: load_main = accept;
            BUSY: begin
                load_main = accept && consume;
                load_skid = accept && !consume;
            end
            FULL: shift_skid = consume && !flush_i;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (load_main) begin
            main_instr_d = instruction_i;
            main_pc_d    = pc_i;
        end else if (shift_skid) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
        end
        if (load_skid) begin
            skid_instr_d = instruction_i;
            skid_pc_d    = pc_i;
        end
    end

    // Payload is qualified by state, so it carries no reset.
    always_ff @(posedge clk_i) begin
        main_instr_q <= main_instr_d;
        main_pc_q    <= main_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign instruction_o = main_instr_q;
    assign pc_o          = main_pc_q;

`ifdef SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_skid_buffer.sv
// Directed self-checking bench for fetch_skid_buffer: streaming, stall/skid, flush, async reset,
// and (with SKID_STALL_CNT_EN) the saturating stall counter.
module tb_fetch_skid_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        ready_i;
`ifdef SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_cmp;
    int n_bad;

    fetch_skid_buffer #(.XLEN(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .ready_i       (ready_i)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction word tied to its PC so payload/PC pairing is visible.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hA5A5, pc[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        valid_i       = v;
        pc_i          = pc;
        instruction_i = instr_of(pc);
        ready_i       = rdy;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
`ifdef SKID_STALL_CNT_EN
        n_cmp++; if (stall_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", stall_cnt_o); end
`endif
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], 1'b1, 1'b0);
            tick();
            n_cmp++; if (valid_o !== 1'b1 || pc_o !== pcs[i]) begin n_bad++; $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", i, valid_o, pc_o, pcs[i]); end
            n_cmp++; if (instruction_o !== instr_of(pcs[i])) begin n_bad++; $display("FAIL stream_instr%0d: got %h want %h", i, instruction_o, instr_of(pcs[i])); end
            n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL stream_ready%0d: got %b want 1", i, ready_o); end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got v=%b want 0", valid_o); end
    endtask

    task automatic test_stall_skid();
        // per edge: inputs, then expected pc_o and ready_o after the edge
        logic        v   [7];
        logic [31:0] ip  [7];
        logic        rdy [7];
        logic        ev  [7];
        logic [31:0] epc [7];
        logic        erd [7];
        v[0]=1; ip[0]=32'h0; rdy[0]=1; ev[0]=1; epc[0]=32'h0; erd[0]=1;
        v[1]=1; ip[1]=32'h4; rdy[1]=0; ev[1]=1; epc[1]=32'h0; erd[1]=0;
        v[2]=1; ip[2]=32'h8; rdy[2]=0; ev[2]=1; epc[2]=32'h0; erd[2]=0;
        v[3]=1; ip[3]=32'h8; rdy[3]=1; ev[3]=1; epc[3]=32'h4; erd[3]=1;
        v[4]=1; ip[4]=32'h8; rdy[4]=1; ev[4]=1; epc[4]=32'h8; erd[4]=1;
        v[5]=1; ip[5]=32'hC; rdy[5]=1; ev[5]=1; epc[5]=32'hC; erd[5]=1;
        v[6]=0; ip[6]=32'h0; rdy[6]=1; ev[6]=0; epc[6]=32'hC; erd[6]=1;
        for (int i = 0; i < 7; i++) begin
            drive(v[i], ip[i], rdy[i], 1'b0);
            tick();
            n_cmp++; if (valid_o !== ev[i]) begin n_bad++; $display("FAIL stall_valid%0d: got %b want %b", i, valid_o, ev[i]); end
            if (ev[i]) begin
                n_cmp++; if (pc_o !== epc[i] || instruction_o !== instr_of(epc[i])) begin n_bad++; $display("FAIL stall_pc%0d: got %h want %h", i, pc_o, epc[i]); end
            end
            n_cmp++; if (ready_o !== erd[i]) begin n_bad++; $display("FAIL stall_ready%0d: got %b want %b", i, ready_o, erd[i]); end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h10, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0); tick();
        n_cmp++; if (ready_o !== 1'b0 || pc_o !== 32'h10) begin n_bad++; $display("FAIL flush_full: got rdy=%b pc=%h want rdy=0 pc=10", ready_o, pc_o); end
        drive(1'b1, 32'h18, 1'b0, 1'b1); tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        drive(1'b1, 32'h100, 1'b1, 1'b0); tick();
        n_cmp++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin n_bad++; $display("FAIL flush_newpc: got v=%b pc=%h want v=1 pc=100", valid_o, pc_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_nostale: got v=%b pc=%h want v=0", valid_o, pc_o); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h20, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h24, 1'b0, 1'b0); tick();
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL areset_full: got rdy=%b want 0", ready_o); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %b want 1", ready_o); end
        #3;
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL areset_after: got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o); end
    endtask

`ifdef SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        drive(1'b1, 32'h30, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) tick();
        n_cmp++; if (stall_cnt_o !== 32'd5) begin n_bad++; $display("FAIL cnt_five: got %0d want 5", stall_cnt_o); end
        drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
        n_cmp++; if (stall_cnt_o !== 32'd5) begin n_bad++; $display("FAIL cnt_flush: got %0d want 5", stall_cnt_o); end
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        n_cmp++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_sat: got %h want ffffffff", stall_cnt_o); end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_ni = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush();
        test_async_reset();
`ifdef SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_skid_buffer.md
# fetch_skid_buffer

- Two-entry elastic buffer between the fetch stage and decode.
- Captures instruction/PC pairs from fetch and presents them to decode with a valid/ready handshake.
- Breaks the combinational ready path back into fetch: its ready output depends only on registered state.
- Discards all buffered instructions on a branch flush.

## Interface
- XLEN, 32, width of instruction word and PC
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  branch taken; drop all buffered and incoming entries this cycle
- valid_i  input  1  fetch presents an instruction
- instruction_i  input  XLEN  instruction word from fetch
- pc_i  input  XLEN  PC of instruction_i
- ready_o  output  1  buffer can accept; equals (state != FULL)
- valid_o  output  1  main register holds an instruction for decode
- instruction_o  output  XLEN  main register instruction
- pc_o  output  XLEN  main register PC
- ready_i  input  1  decode accepts the presented entry
- stall_cnt_o  output  32  decode-stall cycle counter (only with SKID_STALL_CNT_EN)

## Operation
- Storage:
  - main register: drives the outputs
  - skid register: holds overflow while decode stalls
  - each register is XLEN instruction + XLEN PC
- Input accepted when valid_i && ready_o; output consumed when valid_o && ready_i.
- States:
  - EMPTY: main and skid invalid
  - BUSY: main valid, skid invalid
  - FULL: both valid
- EMPTY: accept -> load main, go BUSY.
- BUSY:
  - accept && consume -> reload main, stay BUSY
  - accept && !consume -> load skid, go FULL
  - !accept && consume -> go EMPTY
  - neither -> hold
- FULL: ready_o=0; consume -> main <= skid, go BUSY; else hold.
- flush_i has priority over everything:
  - next state EMPTY
  - any same-cycle input dropped even if valid_i=1
  - a same-cycle handshake on the output side is still considered consumed by decode
- Illegal state encoding -> EMPTY next cycle.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- Data registers need no reset; only state and the counter are reset.

## Timing
- Reset values:
  - state=EMPTY
  - valid_o=0, ready_o=1
  - stall_cnt_o=0
  - instruction_o/pc_o undefined; must not be consumed while valid_o=0
- Latency: an entry accepted at edge N appears on the outputs at edge N (visible the cycle after acceptance); 1 cycle.
- Throughput: one instruction per cycle while ready_i=1; no bubbles.
- ready_o is a pure function of the state register: no combinational path from ready_i or valid_i.
- After a flush asserted in cycle N:
  - valid_o=0 and ready_o=1 in cycle N+1
  - a new-PC instruction presented in N+1 appears on the outputs in N+2
- Reset asserted mid-operation forces EMPTY immediately (asynchronous); contents discarded.
- valid_o and data stay stable while valid_o && !ready_i (AXI-style hold).

## Configuration
- Macro: SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt_o port exists
  - 32-bit counter increments each cycle with valid_o && !ready_i
  - saturates at 0xFFFFFFFF
  - cleared only by reset; flush does not clear it
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, then stream PCs 0x0,0x4,0x8 with valid_i=1 and ready_i=1 -> outputs 0x0,0x4,0x8 on consecutive cycles, ready_o stays 1.
- Stream 0x0..0xC, drop ready_i for 2 cycles after 0x0 is presented -> ready_o falls one cycle after the stall begins, 0x4 held in skid, output order 0x0,0x4,0x8,0xC with no loss or duplicate.
- In FULL (0x10 main, 0x14 skid), pulse flush_i with valid_i=1, pc_i=0x18 -> next cycle valid_o=0, ready_o=1; 0x10, 0x14, 0x18 never delivered; then pc 0x100 appears one cycle after acceptance.
- Assert rst_ni=0 asynchronously mid-cycle while FULL -> valid_o=0 and ready_o=1 immediately, before the next clock edge.
- With SKID_STALL_CNT_EN: hold ready_i=0 for 5 cycles with valid_o=1 -> stall_cnt_o=5; a subsequent flush leaves it at 5; force the counter to 0xFFFFFFFE and stall 3 more cycles -> it sticks at 0xFFFFFFFF.
